// File: rtl/fm_scan_ctrl_p.sv
// Scan-order controller: walks a W x H x C position space one step at a time,
// tracking row parity and a row-group counter for the datapath.
module fm_scan_ctrl_p #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned GRP_N = 3,
  parameter int unsigned GRP_W = $clog2(GRP_N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_w,
  input  logic [CNT_W-1:0] cfg_h,
  input  logic [CNT_W-1:0] cfg_c,
  input  logic             cfg_stride,
  input  logic             cfg_bit_mode,
  input  logic             step_i,
  input  logic             abort_i,
  output logic             busy,
  output logic             done,
  output logic             last_pos,
  output logic [CNT_W-1:0] w_num,
  output logic [CNT_W-1:0] h_num,
  output logic [CNT_W-1:0] c_num,
  output logic             stride_mode,
  output logic             bit_mode,
  output logic [CNT_W-1:0] count_w,
  output logic [CNT_W-1:0] count_h,
  output logic [CNT_W-1:0] count_c,
  output logic             row_parity,
  output logic             is_even_even_row,
  output logic [GRP_W-1:0] grp_cnt
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [GRP_W-1:0] GrpMax = GRP_W'(GRP_N - 1);

  logic [1:0]       st_q, st_d;
  logic [CNT_W-1:0] wn_q, wn_d, hn_q, hn_d, cn_q, cn_d;
  logic             sm_q, sm_d, bm_q, bm_d;
  logic [CNT_W-1:0] cw_q, cw_d, ch_q, ch_d, cc_q, cc_d;
  logic             rp_q, rp_d, eer_q, eer_d;
  logic [GRP_W-1:0] grp_q, grp_d;
  logic             last;

  assign last = (st_q == StRun) && (cw_q == '0) && (ch_q == '0) && (cc_q == '0);

  always_comb begin
    st_d  = st_q;
    wn_d  = wn_q;
    hn_d  = hn_q;
    cn_d  = cn_q;
    sm_d  = sm_q;
    bm_d  = bm_q;
    cw_d  = cw_q;
    ch_d  = ch_q;
    cc_d  = cc_q;
    rp_d  = rp_q;
    eer_d = eer_q;
    grp_d = grp_q;
    case (st_q)
      StIdle: begin
        if (cfg_valid) begin
          wn_d  = cfg_w;
          hn_d  = cfg_h;
          cn_d  = cfg_c;
          sm_d  = cfg_stride;
          bm_d  = cfg_bit_mode;
          cw_d  = cfg_w;
          ch_d  = cfg_h;
          cc_d  = cfg_c;
          rp_d  = 1'b0;
          eer_d = 1'b0;
          grp_d = '0;
          st_d  = StRun;
        end
      end
      StRun: begin
        if (abort_i) begin
          st_d  = StIdle;
          cw_d  = '0;
          ch_d  = '0;
          cc_d  = '0;
          rp_d  = 1'b0;
          eer_d = 1'b0;
          grp_d = '0;
        end else if (step_i) begin
          if (last) begin
            st_d = StDone;
          end else if (cw_q != '0) begin
            cw_d = cw_q - 1'b1;
          end else begin
            // Row end
            cw_d = wn_q;
            rp_d = ~rp_q;
            if (rp_q) eer_d = ~eer_q;
            if (!sm_q || rp_q) grp_d = (grp_q == GrpMax) ? '0 : grp_q + 1'b1;
            if (ch_q != '0) begin
              ch_d = ch_q - 1'b1;
            end else begin
              // Channel wrap: cc_q is nonzero here, otherwise last would be set
              ch_d  = hn_q;
              cc_d  = cc_q - 1'b1;
              rp_d  = 1'b0;
              eer_d = 1'b0;
              grp_d = '0;
            end
          end
        end
      end
      StDone:  st_d = StIdle;
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= StIdle;
      wn_q  <= '0;
      hn_q  <= '0;
      cn_q  <= '0;
      sm_q  <= 1'b0;
      bm_q  <= 1'b0;
      cw_q  <= '0;
      ch_q  <= '0;
      cc_q  <= '0;
      rp_q  <= 1'b0;
      eer_q <= 1'b0;
      grp_q <= '0;
    end else begin
      st_q  <= st_d;
      wn_q  <= wn_d;
      hn_q  <= hn_d;
      cn_q  <= cn_d;
      sm_q  <= sm_d;
      bm_q  <= bm_d;
      cw_q  <= cw_d;
      ch_q  <= ch_d;
      cc_q  <= cc_d;
      rp_q  <= rp_d;
      eer_q <= eer_d;
      grp_q <= grp_d;
    end
  end

  assign cfg_ready        = (st_q == StIdle);
  assign busy             = (st_q == StRun);
  assign done             = (st_q == StDone);
  assign last_pos         = last;
  assign w_num            = wn_q;
  assign h_num            = hn_q;
  assign c_num            = cn_q;
  assign stride_mode      = sm_q;
  assign bit_mode         = bm_q;
  assign count_w          = cw_q;
  assign count_h          = ch_q;
  assign count_c          = cc_q;
  assign row_parity       = rp_q;
  assign is_even_even_row = eer_q;
  assign grp_cnt          = grp_q;

endmodule

// File: tb/tb_fm_scan_ctrl_p.sv
// Randomized and directed bench for fm_scan_ctrl_p against a position-index model.
module tb_fm_scan_ctrl_p;

  localparam int CW = 4;
  localparam int GN = 3;
  localparam int GW = $clog2(GN);

  logic          clk = 1'b0;
  logic          rst, cfg_valid, cfg_stride, cfg_bit_mode, step_i, abort_i;
  logic [CW-1:0] cfg_w, cfg_h, cfg_c;
  logic          cfg_ready, busy, done, last_pos, stride_mode, bit_mode;
  logic          row_parity, is_even_even_row;
  logic [CW-1:0] w_num, h_num, c_num, count_w, count_h, count_c;
  logic [GW-1:0] grp_cnt;

  always #5 clk = ~clk;

  fm_scan_ctrl_p #(.CNT_W(CW), .GRP_N(GN)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_w(cfg_w), .cfg_h(cfg_h), .cfg_c(cfg_c), .cfg_stride(cfg_stride),
    .cfg_bit_mode(cfg_bit_mode), .step_i(step_i), .abort_i(abort_i), .busy(busy),
    .done(done), .last_pos(last_pos), .w_num(w_num), .h_num(h_num), .c_num(c_num),
    .stride_mode(stride_mode), .bit_mode(bit_mode), .count_w(count_w),
    .count_h(count_h), .count_c(count_c), .row_parity(row_parity),
    .is_even_even_row(is_even_even_row), .grp_cnt(grp_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: 0 idle, 1 run, 2 done; k = steps taken in the current traversal.
  int m_st = 0, wn = 0, hn = 0, cn = 0, sm = 0, bm = 0, k = 0;
  bit clr = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic int total();
    return (wn + 1) * (hn + 1) * (cn + 1);
  endfunction

  task automatic model_update(input bit r, input bit cv, input int w, input int h, input int c,
                              input bit s, input bit b, input bit st, input bit ab);
    if (r) begin
      m_st = 0; wn = 0; hn = 0; cn = 0; sm = 0; bm = 0; k = 0; clr = 1'b1;
    end else begin
      case (m_st)
        0: if (cv) begin
          wn = w; hn = h; cn = c; sm = s; bm = b; k = 0; clr = 1'b0; m_st = 1;
        end
        1: if (ab) begin
          m_st = 0; clr = 1'b1;
        end else if (st) begin
          if (k == total() - 1) m_st = 2;
          else k++;
        end
        default: m_st = 0;
      endcase
    end
  endtask

  task automatic check_all();
    int x, r, y, ch, gexp;
    x  = k % (wn + 1);
    r  = k / (wn + 1);
    y  = r % (hn + 1);
    ch = r / (hn + 1);
    gexp = (sm != 0) ? (y / 2) % GN : y % GN;
    check_eq("cfg_ready", 32'(cfg_ready), 32'(m_st == 0));
    check_eq("busy", 32'(busy), 32'(m_st == 1));
    check_eq("done", 32'(done), 32'(m_st == 2));
    check_eq("last_pos", 32'(last_pos), 32'(m_st == 1 && k == total() - 1));
    check_eq("w_num", 32'(w_num), wn);
    check_eq("h_num", 32'(h_num), hn);
    check_eq("c_num", 32'(c_num), cn);
    check_eq("stride_mode", 32'(stride_mode), sm);
    check_eq("bit_mode", 32'(bit_mode), bm);
    check_eq("count_w", 32'(count_w), clr ? 0 : wn - x);
    check_eq("count_h", 32'(count_h), clr ? 0 : hn - y);
    check_eq("count_c", 32'(count_c), clr ? 0 : cn - ch);
    check_eq("row_parity", 32'(row_parity), clr ? 0 : y % 2);
    check_eq("even_even", 32'(is_even_even_row), clr ? 0 : (y / 2) % 2);
    check_eq("grp_cnt", 32'(grp_cnt), clr ? 0 : gexp);
  endtask

  // Drive one cycle's inputs at the falling edge, clock them, then compare.
  task automatic cyc(input bit r, input bit cv, input int w, input int h, input int c,
                     input bit s, input bit b, input bit st, input bit ab);
    rst = r; cfg_valid = cv; cfg_w = w[CW-1:0]; cfg_h = h[CW-1:0]; cfg_c = c[CW-1:0];
    cfg_stride = s; cfg_bit_mode = b; step_i = st; abort_i = ab;
    @(posedge clk);
    model_update(r, cv, w, h, c, s, b, st, ab);
    @(negedge clk);
    check_all();
  endtask

  task automatic stepn(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  int g36 [7] = '{0, 1, 1, 2, 2, 0, 0};
  int e36 [7] = '{0, 1, 1, 0, 0, 1, 1};
  int g35 [3] = '{1, 0, 1};
  int n;

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_w = '0; cfg_h = '0; cfg_c = '0;
    cfg_stride = 1'b0; cfg_bit_mode = 1'b0; step_i = 1'b0; abort_i = 1'b0;
    @(negedge clk);
    // Reset with step and cfg_valid high must have no effect
    cyc(1, 1, 3, 3, 3, 1, 1, 1, 0);
    cyc(1, 1, 3, 3, 3, 1, 1, 1, 0);

    // 3x2x2 traversal, stride 0
    cyc(0, 1, 2, 1, 1, 0, 1, 0, 0);
    for (int i = 1; i <= 12; i++) begin
      stepn(1);
      if (i % 3 == 0 && i < 12) check_eq("grp_row35", 32'(grp_cnt), g35[i / 3 - 1]);
    end
    check_eq("done_after12", 32'(done), 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    check_eq("ready_after_done", 32'(cfg_ready), 1);

    // Single column, 8 rows, stride 1
    cyc(0, 1, 0, 7, 0, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      stepn(1);
      check_eq("grp_row36", 32'(grp_cnt), g36[i]);
      check_eq("eer_row36", 32'(is_even_even_row), e36[i]);
    end
    stepn(2);

    // All-zero configuration
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    check_eq("zero_busy", 32'(busy), 1);
    stepn(1);
    check_eq("zero_done", 32'(done), 1);
    stepn(1);

    // Abort with simultaneous step, then immediate reconfigure
    cyc(0, 1, 3, 3, 3, 0, 0, 0, 0);
    stepn(5);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc(0, 1, 1, 1, 1, 1, 0, 0, 0);
    check_eq("accept_after_abort", 32'(busy), 1);
    stepn(3);

    // Reset mid-run with step high, cfg_valid held through reset
    cyc(0, 1, 2, 2, 2, 0, 0, 1, 0);
    cyc(1, 1, 2, 2, 2, 0, 0, 1, 0);
    cyc(1, 1, 2, 2, 2, 0, 0, 1, 0);
    cyc(0, 1, 2, 2, 2, 0, 1, 0, 0);
    check_eq("accept_after_rst", 32'(busy), 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Full 16x16x16 traversal with cfg_valid toggling
    cyc(0, 1, 15, 15, 15, 1, 0, 0, 0);
    n = 0;
    while (!done && n < 5000) begin
      cyc(0, n[0], 0, 0, 0, 0, 0, 1, 0);
      n++;
    end
    check_eq("steps_4096", n, 4096);
    stepn(1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fm_scan_ctrl_p.md
FM_SCAN_CTRL_P -- requirements
Module: fm_scan_ctrl_p

Interface
REQ-001 Parameter CNT_W, default 8: width of the dimension fields and counters.
REQ-002 Parameter GRP_N, default 3: modulus of the row-group counter; legal range 2..16.
REQ-003 Parameter GRP_W, default $clog2(GRP_N): derived width of grp_cnt; never overridden.
REQ-004 Port clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 Port rst  in  1  reset, synchronous and active-high.
REQ-006 Ports cfg_valid in 1 / cfg_ready out 1: configuration handshake; accepted on the edge where both are 1.
REQ-007 Ports cfg_w, cfg_h, cfg_c  in  CNT_W each: last index per dimension; extent is value+1.
REQ-008 Ports cfg_stride in 1 (0 = group advance every row, 1 = every second row) / cfg_bit_mode in 1 (pass-through).
REQ-009 Port step_i  in  1  advance one position; the psum-almost-valid strobe from the datapath.
REQ-010 Port abort_i  in  1  terminate the current traversal.
REQ-011 Ports busy out 1 / done out 1 (one-cycle pulse) / last_pos out 1 (current position is the final one).
REQ-012 Ports w_num, h_num, c_num  out  CNT_W each; stride_mode out 1; bit_mode out 1: registered configuration.
REQ-013 Ports count_w, count_h, count_c  out  CNT_W each: down-counters.
REQ-014 Ports row_parity out 1; is_even_even_row out 1; grp_cnt out GRP_W.

Function
REQ-015 FSM states are IDLE, RUN and DONE; reset state is IDLE.
REQ-016 cfg_ready SHALL be 1 only in IDLE; busy SHALL be 1 only in RUN.
REQ-017 On acceptance: latch all cfg fields into the *_num/mode registers, load count_w/h/c with cfg_w/h/c, clear row_parity, is_even_even_row and grp_cnt, and go to RUN.
REQ-018 In RUN, step_i with count_w != 0 SHALL only decrement count_w.
REQ-019 Row end (step_i, count_w == 0): reload count_w = w_num; toggle row_parity; toggle is_even_even_row if row_parity was 1; advance grp_cnt if stride_mode == 0 or row_parity was 1.
REQ-020 grp_cnt SHALL wrap from GRP_N-1 to 0.
REQ-021 At row end with count_h != 0, decrement count_h.
REQ-022 At row end with count_h == 0 and count_c != 0 (channel wrap): reload count_h = h_num; decrement count_c; clear row_parity, is_even_even_row and grp_cnt; this clear overrides REQ-019.
REQ-023 last_pos SHALL be combinational: 1 in RUN when count_w, count_h and count_c are all 0.
REQ-024 step_i with last_pos = 1 SHALL move to DONE; counters hold their values.
REQ-025 The traversal SHALL accept exactly (w_num+1)*(h_num+1)*(c_num+1) steps.
REQ-026 done SHALL be 1 for exactly the one cycle spent in DONE, then the FSM returns to IDLE.
REQ-027 done SHALL not assert more than once per accepted configuration.
REQ-028 step_i SHALL be ignored in IDLE and DONE; cfg_valid SHALL be ignored outside IDLE.
REQ-029 abort_i in RUN SHALL go to IDLE next cycle with no done pulse and counters/row state cleared.
REQ-030 abort_i has priority over a simultaneous step_i; abort_i SHALL be ignored in IDLE and DONE.
REQ-031 All arithmetic is unsigned at CNT_W bits; counters never decrement below 0.
REQ-032 A configuration with all-zero dimensions SHALL be legal: one step leads to done.

Reset
REQ-033 rst SHALL force IDLE, cfg_ready = 1, busy = 0, done = 0, and all other outputs 0, from any state including mid-RUN.
REQ-034 A step_i coinciding with rst SHALL have no effect.

Verification
REQ-035 Config w=2, h=1, c=1, stride 0; 12 steps: done on the cycle after step 12, never earlier; grp_cnt sequence per row 1, 0 (clear at channel wrap), 1; cfg_ready back to 1.
REQ-036 GRP_N=3, w=0, h=7, c=0, stride 1: grp_cnt after each row end = 0,1,1,2,2,0,0; is_even_even_row toggles on rows 2, 4, 6.
REQ-037 All-zero config followed by a single step: busy for 1 cycle, done pulses once, then IDLE.
REQ-038 Abort with a simultaneous step mid-RUN: no done; next cycle in IDLE with counters at 0; a new configuration is accepted on the following cycle.
REQ-039 rst asserted mid-RUN with step_i high: all outputs at reset values next cycle; cfg_valid held high before and during rst is not accepted until the first cycle after rst deasserts.
REQ-040 CNT_W=4 with w=h=c=15: exactly 4096 steps to done; no counter underflow; cfg_valid toggling during RUN is ignored.
